// File: rtl/hum_pkg.sv
// Shared constants for the humidity alarm scanner: 7-segment codes and size limits.
package hum_pkg;

    localparam int MAX_NSENS = 10;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Segment order {dp,g,f,e,d,c,b,a}; dp is never set here.
    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
        8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
    };

endpackage

// File: rtl/hum_debounce.sv
// Single-input debouncer: the output flips only after the input has disagreed
// with it for DEB_CYCLES consecutive clocks.
module hum_debounce #(
    parameter int DEB_CYCLES = 3
) (
    input  logic clk_2,
    input  logic reset,
    input  logic din,
    output logic deb
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_2) begin
        if (reset) begin
            cnt <= '0;
            deb <= 1'b0;
        end else if (din != deb) begin
            // The DEB_CYCLES-th disagreeing sample is the one that flips deb.
            if (cnt == CW'(DEB_CYCLES - 1)) begin
                deb <= din;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/humidity_alarm_scan.sv
// Multi-sensor humidity alarm: debounce, latch until ack, scan alarmed sensor numbers
// onto one 7-segment digit. Optional HUM_MULTI_DP_EN lights dp when 2+ alarms are latched.
module humidity_alarm_scan
    import hum_pkg::*;
#(
    parameter int NSENS      = 4,
    parameter int DEB_CYCLES = 3,
    parameter int DWELL      = 4
) (
    input  logic                       clk_2,
    input  logic                       reset,
    input  logic [NSENS-1:0]           low_hum,
    input  logic                       ack,
    output logic [7:0]                 seg,
    output logic [NSENS-1:0]           alarm_vec,
    output logic                       alarm_any,
    output logic [$clog2(NSENS+1)-1:0] alarm_cnt
);

    localparam int PTR_W = (NSENS > 1) ? $clog2(NSENS) : 1;
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int CNT_W = $clog2(NSENS + 1);

    logic [NSENS-1:0] deb;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] next_ptr;
    logic [DW_W-1:0]  dwell;
    logic [7:0]       shown;
    logic             dp;

    genvar gi;
    generate
        for (gi = 0; gi < NSENS; gi++) begin : g_deb
            hum_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_deb (
                .clk_2 (clk_2),
                .reset (reset),
                .din   (low_hum[gi]),
                .deb   (deb[gi])
            );
        end
    endgenerate

    // A fresh debounced alarm outranks an ack arriving in the same cycle.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            alarm_vec <= '0;
        end else begin
            alarm_vec <= deb | (alarm_vec & ~{NSENS{ack}});
        end
    end

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NSENS - 1)) ? '0 : p + 1'b1;
    endfunction

    // Circular search from ptr+1; lands back on ptr when it is the only alarm.
    always_comb begin
        logic [PTR_W-1:0] cand;
        logic             found;
        next_ptr = ptr;
        cand     = ptr;
        found    = 1'b0;
        for (int k = 0; k < NSENS; k++) begin
            cand = wrap_inc(cand);
            if (!found && alarm_vec[cand]) begin
                next_ptr = cand;
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            ptr   <= '0;
            dwell <= '0;
        end else if (alarm_vec == '0) begin
            ptr   <= ptr;
            dwell <= dwell;
        end else if (!alarm_vec[ptr]) begin
            ptr   <= next_ptr;
            dwell <= '0;
        end else if (dwell == DW_W'(DWELL - 1)) begin
            ptr   <= next_ptr;
            dwell <= '0;
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    always_comb begin
        alarm_cnt = '0;
        for (int i = 0; i < NSENS; i++) begin
            alarm_cnt = alarm_cnt + CNT_W'(alarm_vec[i]);
        end
    end

    assign alarm_any = |alarm_vec;

    // Display decode looks only at registered state, never at low_hum or ack.
    always_comb begin
        shown = SEG_BLANK;
        if (alarm_vec[ptr]) begin
            for (int i = 0; i < NSENS; i++) begin
                if (ptr == PTR_W'(i)) begin
                    shown = SEG_DIGIT[i];
                end
            end
        end
    end

`ifdef HUM_MULTI_DP_EN
    assign dp = (alarm_cnt >= CNT_W'(2));
`else
    assign dp = 1'b0;
`endif

    assign seg = {dp, shown[6:0]};

endmodule

// File: tb/tb_humidity_alarm_scan.sv
// Randomized and directed bench for humidity_alarm_scan against a behavioural model.
module tb_humidity_alarm_scan;

    localparam int N   = 4;
    localparam int DEB = 3;
    localparam int DW  = 4;

    logic         clk_2 = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] low_hum = '0;
    logic         ack = 1'b0;
    logic [7:0]   seg;
    logic [N-1:0] alarm_vec;
    logic         alarm_any;
    logic [2:0]   alarm_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] dig [0:9] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                              8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    // Model state: debounced level, last raw sample and its run length, latched alarms, scan.
    logic [N-1:0] m_deb;
    logic [N-1:0] m_last;
    int           m_run [N];
    logic [N-1:0] m_alarm;
    int           m_ptr;
    int           m_dwell;

    humidity_alarm_scan #(
        .NSENS      (N),
        .DEB_CYCLES (DEB),
        .DWELL      (DW)
    ) dut (
        .clk_2     (clk_2),
        .reset     (reset),
        .low_hum   (low_hum),
        .ack       (ack),
        .seg       (seg),
        .alarm_vec (alarm_vec),
        .alarm_any (alarm_any),
        .alarm_cnt (alarm_cnt)
    );

    always #5 clk_2 = ~clk_2;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int next_alarm(input int p);
        for (int k = 1; k <= N; k++) begin
            if (m_alarm[(p + k) % N]) return (p + k) % N;
        end
        return p;
    endfunction

    task automatic model_reset();
        m_deb   = '0;
        m_last  = '0;
        m_alarm = '0;
        m_ptr   = 0;
        m_dwell = 0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
    endtask

    task automatic model_step(input logic r, input logic [N-1:0] lh, input logic a);
        logic [N-1:0] na;
        if (r) begin
            model_reset();
        end else begin
            for (int i = 0; i < N; i++) na[i] = m_deb[i] | (m_alarm[i] & ~a);
            if (m_alarm != '0) begin
                if (!m_alarm[m_ptr] || m_dwell == DW - 1) begin
                    m_ptr   = next_alarm(m_ptr);
                    m_dwell = 0;
                end else begin
                    m_dwell++;
                end
            end
            // Debounced level is the value of the latest raw run at least DEB samples long.
            for (int i = 0; i < N; i++) begin
                if (lh[i] == m_last[i]) begin
                    m_run[i]++;
                end else begin
                    m_run[i]  = 1;
                    m_last[i] = lh[i];
                end
                if (m_run[i] >= DEB) m_deb[i] = lh[i];
            end
            m_alarm = na;
        end
    endtask

    function automatic logic [7:0] exp_seg();
        logic [7:0] s;
        int         cnt;
        s   = m_alarm[m_ptr] ? dig[m_ptr] : 8'h00;
        cnt = $countones(m_alarm);
`ifdef HUM_MULTI_DP_EN
        s[7] = (cnt >= 2);
`else
        s[7] = 1'b0;
`endif
        return s;
    endfunction

    task automatic run_cycle(input logic r, input logic [N-1:0] lh, input logic a);
        @(negedge clk_2);
        reset   = r;
        low_hum = lh;
        ack     = a;
        @(posedge clk_2);
        model_step(r, lh, a);
        #1;
        check_eq("alarm_vec", 32'(alarm_vec), 32'(m_alarm));
        check_eq("seg", 32'(seg), 32'(exp_seg()));
        check_eq("alarm_any", 32'(alarm_any), 32'(m_alarm != '0));
        check_eq("alarm_cnt", 32'(alarm_cnt), 32'($countones(m_alarm)));
    endtask

    initial begin
        logic [N-1:0] lh;
        int           hold;
        model_reset();
        @(posedge clk_2);

        // Reset held with all inputs asserted.
        run_cycle(1'b1, 4'hF, 1'b0);
        run_cycle(1'b1, 4'hF, 1'b0);
        check_eq("reset_seg", 32'(seg), 32'h00);

        // Two-cycle glitch on sensor 1 is rejected.
        run_cycle(1'b0, 4'b0010, 1'b0);
        run_cycle(1'b0, 4'b0010, 1'b0);
        for (int i = 0; i < 4; i++) run_cycle(1'b0, 4'b0000, 1'b0);
        check_eq("glitch_vec", 32'(alarm_vec), 32'h0);

        // Sensor 0 steady: alarm on the 4th edge.
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 4'b0001, 1'b0);
        check_eq("s0_pre", 32'(alarm_vec), 32'h0);
        run_cycle(1'b0, 4'b0001, 1'b0);
        check_eq("s0_vec", 32'(alarm_vec), 32'h1);
        check_eq("s0_seg", 32'(seg), 32'h3F);
        check_eq("s0_cnt", 32'(alarm_cnt), 32'd1);

        // Two alarms alternate on the display.
        for (int i = 0; i < 24; i++) run_cycle(1'b0, 4'b0101, 1'b0);
        check_eq("pair_cnt", 32'(alarm_cnt), 32'd2);

        // Ack while still low keeps the alarm; after inputs clear, ack drops it.
        run_cycle(1'b0, 4'b0101, 1'b1);
        check_eq("ack_hold", 32'(alarm_vec[0]), 32'd1);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 4'b0000, 1'b0);
        run_cycle(1'b0, 4'b0000, 1'b1);
        check_eq("ack_clear", 32'(alarm_vec), 32'h0);
        check_eq("ack_seg", 32'(seg), 32'h00);

        // Reset mid-scan with ack asserted, then relatch.
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 4'b0101, 1'b0);
        run_cycle(1'b1, 4'b0101, 1'b1);
        check_eq("mid_rst_vec", 32'(alarm_vec), 32'h0);
        check_eq("mid_rst_seg", 32'(seg), 32'h00);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 4'b0101, 1'b0);
        check_eq("relatch_pre", 32'(alarm_vec), 32'h0);
        run_cycle(1'b0, 4'b0101, 1'b0);
        check_eq("relatch", 32'(alarm_vec), 32'h5);

        // Random held patterns with occasional ack and reset.
        for (int n = 0; n < 150; n++) begin
            lh   = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 7);
            for (int c = 0; c < hold; c++) begin
                run_cycle(($urandom_range(0, 199) == 0), lh, ($urandom_range(0, 7) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
